rr_mux_arbiter: RTL and testbench

Two-input, valid/ready round-robin arbiter that sits directly upstream of the day1 8-bit 2:1 mux and drives its select. Each input stream is buffered in a one-entry holding register. A grant picks one holding register, and the selected word is registered into a single-entry output stage with valid/ready. Turns the free-running combinational mux into a flow-controlled, fair stream merger.

---
 rtl/rr_mux_pkg.sv | 11 +
 rtl/rr_mux_arbiter_mux2.sv | 14 +
 rtl/rr_mux_arbiter.sv | 116 +++++++++++
 tb/tb_rr_mux_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rr_mux_pkg.sv
// Shared source encodings and default width for the round-robin mux arbiter.
package rr_mux_pkg;

   localparam int unsigned DATA_W_DEFAULT = 8;

   typedef logic src_t;

   localparam src_t SRC_A = 1'b0;
   localparam src_t SRC_B = 1'b1;

endpackage

// File: rtl/rr_mux_arbiter_mux2.sv
// Plain combinational 2:1 word mux (the day1 mux); sel_i=0 picks a_i.
module rr_mux_arbiter_mux2
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             sel_i,
   output logic [WIDTH-1:0] y_o
);

   assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/rr_mux_arbiter.sv
// Two-stream valid/ready merger: one-entry holding register per input, round-robin
// grant into a registered output stage. Define RR_MUX_ARBITER_FIXED_PRIO_EN for A-first priority.
module rr_mux_arbiter
   import rr_mux_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              a_valid_i,
   input  logic [DATA_W-1:0] a_data_i,
   output logic              a_ready_o,
   input  logic              b_valid_i,
   input  logic [DATA_W-1:0] b_data_i,
   output logic              b_ready_o,
   output logic              y_valid_o,
   output logic [DATA_W-1:0] y_data_o,
   input  logic              y_ready_i,
   output logic              sel_o
);

   logic              a_full;
   logic              b_full;
   logic [DATA_W-1:0] a_data_q;
   logic [DATA_W-1:0] b_data_q;
   logic [DATA_W-1:0] mux_y;
   logic              out_free;
   logic              grant_vld;
   logic              grant_a;
   logic              grant_b;
   src_t              grant_src;
`ifndef RR_MUX_ARBITER_FIXED_PRIO_EN
   src_t              rr_ptr;
`endif

   // Grant selection: a lone full register wins; a tie goes to the pointer (or A).
   always_comb begin
      out_free  = !y_valid_o || y_ready_i;
      grant_src = SRC_A;
      if (a_full && b_full) begin
`ifdef RR_MUX_ARBITER_FIXED_PRIO_EN
         grant_src = SRC_A;
`else
         grant_src = rr_ptr;
`endif
      end else if (b_full) begin
         grant_src = SRC_B;
      end
      grant_vld = out_free && (a_full || b_full);
      grant_a   = grant_vld && (grant_src == SRC_A);
      grant_b   = grant_vld && (grant_src == SRC_B);
   end

   // A register being drained this cycle can refill in the same cycle.
   assign a_ready_o = !a_full || grant_a;
   assign b_ready_o = !b_full || grant_b;

   rr_mux_arbiter_mux2 #(
      .WIDTH (DATA_W)
   ) u_mux (
      .a_i   (a_data_q),
      .b_i   (b_data_q),
      .sel_i (grant_src),
      .y_o   (mux_y)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         a_full   <= 1'b0;
         a_data_q <= '0;
      end else if (a_valid_i && a_ready_o) begin
         a_full   <= 1'b1;
         a_data_q <= a_data_i;
      end else if (grant_a) begin
         a_full   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         b_full   <= 1'b0;
         b_data_q <= '0;
      end else if (b_valid_i && b_ready_o) begin
         b_full   <= 1'b1;
         b_data_q <= b_data_i;
      end else if (grant_b) begin
         b_full   <= 1'b0;
      end
   end

   // Output stage: load on grant, otherwise clear valid once the word is taken.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         y_valid_o <= 1'b0;
         y_data_o  <= '0;
         sel_o     <= SRC_A;
      end else if (grant_vld) begin
         y_valid_o <= 1'b1;
         y_data_o  <= mux_y;
         sel_o     <= grant_src;
      end else if (y_ready_i) begin
         y_valid_o <= 1'b0;
      end
   end

`ifndef RR_MUX_ARBITER_FIXED_PRIO_EN
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         rr_ptr <= SRC_A;
      end else if (grant_vld) begin
         rr_ptr <= src_t'(~grant_src);
      end
   end
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed self-checking bench for rr_mux_arbiter (both priority modes).
`timescale 1ns/1ps
module tb_rr_mux_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       a_valid_i, b_valid_i, y_ready_i;
   logic [7:0] a_data_i, b_data_i;
   logic       a_ready_o, b_ready_o, y_valid_o, sel_o;
   logic [7:0] y_data_o;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   rr_mux_arbiter #(.DATA_W(8)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .a_valid_i (a_valid_i),
      .a_data_i  (a_data_i),
      .a_ready_o (a_ready_o),
      .b_valid_i (b_valid_i),
      .b_data_i  (b_data_i),
      .b_ready_o (b_ready_o),
      .y_valid_o (y_valid_o),
      .y_data_o  (y_data_o),
      .y_ready_i (y_ready_i),
      .sel_o     (sel_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [7:0] ad,
                        input logic bv, input logic [7:0] bd, input logic yr);
      a_valid_i = av;
      a_data_i  = ad;
      b_valid_i = bv;
      b_data_i  = bd;
      y_ready_i = yr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [7:0] d, input logic s);
      check({tag, ".valid"}, 32'(y_valid_o), 32'(v));
      if (v) begin
         check({tag, ".data"}, 32'(y_data_o), 32'(d));
         check({tag, ".sel"},  32'(sel_o),    32'(s));
      end
   endtask

   task automatic check_rdy(input string tag, input logic ar, input logic br);
      #1;
      check({tag, ".a_ready"}, 32'(a_ready_o), 32'(ar));
      check({tag, ".b_ready"}, 32'(b_ready_o), 32'(br));
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();
      reset_n = 1'b1;
   endtask

   initial begin
      int na;
      int nb;
      logic ga;
      reset_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

      // 1: reset with random inputs
      for (int i = 0; i < 3; i++) begin
         drive(1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));
         tick();
         check("rst.valid", 32'(y_valid_o), 32'd0);
         check("rst.data",  32'(y_data_o),  32'd0);
         check("rst.sel",   32'(sel_o),     32'd0);
      end
      reset_n = 1'b1;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check_rdy("rst", 1'b1, 1'b1);

      // 2: single stream A, 2-cycle latency, one word per cycle
      drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
      tick();
      check_out("a1.lat", 1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'h22, 1'b0, 8'h00, 1'b1);
      check_rdy("a1.nobubble", 1'b1, 1'b1);
      tick();
      check_out("a1.w0", 1'b1, 8'h11, 1'b0);
      drive(1'b1, 8'h33, 1'b0, 8'h00, 1'b1);
      tick();
      check_out("a1.w1", 1'b1, 8'h22, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      check_out("a1.w2", 1'b1, 8'h33, 1'b0);
      tick();
      check_out("a1.idle", 1'b0, 8'h00, 1'b0);

`ifndef RR_MUX_ARBITER_FIXED_PRIO_EN
      // 3: contention alternates A,B,A,B
      do_reset();
      drive(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
      check_rdy("rr.fill", 1'b1, 1'b1);
      tick();
      na = 1;
      nb = 1;
      for (int k = 1; k <= 8; k++) begin
         ga = k[0];
         drive(1'b1, 8'(8'hA0 + na), 1'b1, 8'(8'hB0 + nb), 1'b1);
         check_rdy("rr.rdy", ga, !ga);
         tick();
         if (ga) check_out("rr.out", 1'b1, 8'(8'hA0 + (k - 1) / 2), 1'b0);
         else    check_out("rr.out", 1'b1, 8'(8'hB0 + k / 2 - 1), 1'b1);
         if (ga) na++;
         else    nb++;
      end

      // 4: backpressure freezes output, then drains in rr order
      do_reset();
      drive(1'b1, 8'h41, 1'b1, 8'h51, 1'b0);
      tick();
      drive(1'b1, 8'h42, 1'b1, 8'h52, 1'b0);
      check_rdy("bp.first", 1'b1, 1'b0);
      tick();
      check_out("bp.first", 1'b1, 8'h41, 1'b0);
      drive(1'b1, 8'h43, 1'b1, 8'h52, 1'b0);
      for (int i = 0; i < 5; i++) begin
         check_rdy("bp.hold", 1'b0, 1'b0);
         tick();
         check_out("bp.hold", 1'b1, 8'h41, 1'b0);
      end
      drive(1'b1, 8'h43, 1'b1, 8'h52, 1'b1);
      check_rdy("bp.rel", 1'b0, 1'b1);
      tick();
      check_out("bp.d0", 1'b1, 8'h51, 1'b1);
      drive(1'b1, 8'h43, 1'b0, 8'h00, 1'b1);
      check_rdy("bp.d1", 1'b1, 1'b0);
      tick();
      check_out("bp.d1", 1'b1, 8'h42, 1'b0);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      check_out("bp.d2", 1'b1, 8'h52, 1'b1);
      tick();
      check_out("bp.d3", 1'b1, 8'h43, 1'b0);
      tick();
      check_out("bp.empty", 1'b0, 8'h00, 1'b0);
`else
      // 6: fixed priority, A always wins, B starves
      do_reset();
      drive(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
      tick();
      for (int k = 1; k <= 6; k++) begin
         drive(1'b1, 8'(8'hA0 + k), 1'b1, 8'hB1, 1'b1);
         check_rdy("fp.rdy", 1'b1, 1'b0);
         tick();
         check_out("fp.out", 1'b1, 8'(8'hA0 + k - 1), 1'b0);
      end
`endif

      // 5: reset mid-operation drops buffered words, pointer back to A
      do_reset();
      drive(1'b1, 8'h81, 1'b1, 8'h91, 1'b0);
      tick();
      drive(1'b1, 8'h82, 1'b1, 8'h92, 1'b0);
      tick();
      check_out("mr.pre", 1'b1, 8'h81, 1'b0);
      reset_n = 1'b0;
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
      tick();
      reset_n = 1'b1;
      check("mr.valid", 32'(y_valid_o), 32'd0);
      check("mr.data",  32'(y_data_o),  32'd0);
      check("mr.sel",   32'(sel_o),     32'd0);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      check_rdy("mr.empty", 1'b1, 1'b1);
      tick();
      check_out("mr.nodata", 1'b0, 8'h00, 1'b0);
      drive(1'b1, 8'h61, 1'b1, 8'h71, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
      tick();
      check_out("mr.w0", 1'b1, 8'h61, 1'b0);
      tick();
      check_out("mr.w1", 1'b1, 8'h71, 1'b1);
      tick();
      check_out("mr.idle", 1'b0, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
